vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_SYNC, 96, horizontal sync width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_DISPLAY, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_SYNC, 2, vertical sync width in lines
- V_BACK, 33, vertical back porch in lines
- HSYNC_POL, 0, active level of Hsync
- VSYNC_POL, 0, active level of Vsync
- CLK_DIV, 2, Clk cycles per pixel, at least 1
- PIPE_DLY, 0, pixel-tick delay on sync and video outputs, 0 to 7
- CW, 11, counter width
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- Clk, in, 1, sole clock
- Reset, in, 1, synchronous, active-high
- En, in, 1, timing advance enable
- pixel_tick, out, 1, pixel strobe
- X, out, CW, current column
- Y, out, CW, current line
- Hsync, out, 1, horizontal sync at HSYNC_POL
- Vsync, out, 1, vertical sync at VSYNC_POL
- video_on, out, 1, visible region
- line_start, out, 1, one-Clk pulse at X=0
- frame_start, out, 1, one-Clk pulse at (0,0)
- frame_cnt, out, 16, frames started
REQ-003 There SHALL be one clock, Clk; Reset SHALL be synchronous and active-high.

Function
REQ-004 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK and V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK; both SHALL fit in CW bits.
REQ-005 A divider counting 0..CLK_DIV-1 SHALL advance only while En=1; pixel_tick = En AND (divider = CLK_DIV-1) AND NOT Reset; CLK_DIV=1 gives pixel_tick = En.
REQ-006 On pixel_tick: X increments; X = H_TOTAL-1 wraps to 0 and Y increments; Y = V_TOTAL-1 together with the X wrap sets Y to 0.
REQ-007 With En=0, the divider, X, Y, the delay line and all outputs SHALL hold; line_start and frame_start SHALL be 0.
REQ-008 Line order SHALL be display, front porch, sync, back porch. Hsync is active for X in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]; the same rule applies to Vsync on Y.
REQ-009 Undelayed decode: video_on_raw = (X<H_DISPLAY) AND (Y<V_DISPLAY). The decode SHALL be registered on the same edge as X/Y (computed from next counts), so with PIPE_DLY=0 it aligns exactly with X/Y.
REQ-010 For PIPE_DLY=N>0, {Hsync,Vsync,video_on} SHALL pass through N register stages that advance only on pixel_tick; the outputs then correspond to the X/Y value N ticks earlier. X and Y SHALL never be delayed.
REQ-011 line_start SHALL be 1 for exactly the Clk cycle after the tick that sets X to 0; frame_start likewise when (X,Y) becomes (0,0). Both are undelayed.
REQ-012 frame_cnt SHALL increment by 1 with each frame_start and wrap from 65535 to 0.
REQ-013 Inactive sync SHALL be driven as the inverted polarity level (~HSYNC_POL, ~VSYNC_POL).

Reset
REQ-014 On a Clk edge with Reset=1, the block SHALL set: divider=0, X=H_TOTAL-1, Y=V_TOTAL-1, Hsync/Vsync inactive, video_on=0, all delay stages inactive (video 0), line_start=frame_start=0, frame_cnt=0, and pixel_tick=0 while Reset=1.
REQ-015 The first pixel_tick after reset SHALL move to (0,0), pulse line_start and frame_start, and set frame_cnt to 1.
REQ-016 Reset asserted mid-frame SHALL take priority over En and pixel_tick, with no partial-line residue.

Verification
REQ-017 Defaults, En=1: Hsync low exactly for X=656..751 (96 ticks = 192 Clk); line period 1600 Clk; video_on high for X=0..639 on Y<480.
REQ-018 Defaults: Vsync low only for Y=490..491; frame_start every 420000 ticks; frame_cnt reads 1, 2, 3 at successive frame_starts.
REQ-019 En=0 at X=100 for 50 Clk: X stays 100, pixel_tick=0, no pulses; after resume, X=101 follows CLK_DIV Clk later.
REQ-020 PIPE_DLY=3: video_on rises 3 ticks after X becomes 0 and falls 3 ticks after X=640; Hsync is likewise shifted by 3.
REQ-021 Reset pulse at Y=300: next cycle X=799, Y=524, Hsync=Vsync=1, video_on=0, frame_cnt=0; the next tick gives (0,0) with frame_start.
REQ-022 Minimal case, H=8/2/3/2, V=4/1/1/1, HSYNC_POL=1, CLK_DIV=1: Hsync high for X=10..12, line length 15 Clk, Vsync low for Y=5 only.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel-rate divider, X/Y raster counters, and sync/video
// decode with an optional pixel-tick delay line. Line and frame strobes are never delayed.
module vga_timing_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned CLK_DIV   = 2,
    parameter int unsigned PIPE_DLY  = 0,
    parameter int unsigned CW        = 11
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          En,
    output logic          pixel_tick,
    output logic [CW-1:0] X,
    output logic [CW-1:0] Y,
    output logic          Hsync,
    output logic          Vsync,
    output logic          video_on,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_cnt
);

    localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
    localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned SW       = 3;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] X_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST   = CW'(V_TOTAL - 1);
    // Delay-line payload is {hsync, vsync, video_on}; idle value is both syncs inactive, video off.
    localparam logic [SW-1:0] IDLE     = {~HSYNC_POL, ~VSYNC_POL, 1'b0};

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic [CW-1:0] x_d;
    logic [CW-1:0] y_d;
    logic          line_wrap_c;
    logic          frame_wrap_c;
    logic [SW-1:0] dec_d;
    logic [SW-1:0] pipe_q [0:PIPE_DLY];

    assign pixel_tick = En & (div_q == DIV_LAST) & ~Reset;

    // Divider advances only on enabled cycles.
    always_comb begin
        div_d = div_q;
        if (En) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end
    end

    // Raster position the next pixel tick would produce.
    always_comb begin
        x_d = X + CW'(1);
        y_d = Y;
        if (X == X_LAST) begin
            x_d = '0;
            y_d = (Y == Y_LAST) ? '0 : Y + CW'(1);
        end
    end

    assign line_wrap_c  = (x_d == '0);
    assign frame_wrap_c = line_wrap_c & (y_d == '0);

    // Decode from the next counts so the undelayed stage lines up with X/Y.
    always_comb begin
        dec_d    = IDLE;
        dec_d[2] = ((x_d >= CW'(HS_START)) && (x_d <= CW'(HS_END))) ? HSYNC_POL : ~HSYNC_POL;
        dec_d[1] = ((y_d >= CW'(VS_START)) && (y_d <= CW'(VS_END))) ? VSYNC_POL : ~VSYNC_POL;
        dec_d[0] = (x_d < CW'(H_DISPLAY)) && (y_d < CW'(V_DISPLAY));
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div_q       <= '0;
            X           <= X_LAST;
            Y           <= Y_LAST;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            for (int unsigned k = 0; k <= PIPE_DLY; k++) begin
                pipe_q[k] <= IDLE;
            end
        end else begin
            div_q       <= div_d;
            line_start  <= pixel_tick & line_wrap_c;
            frame_start <= pixel_tick & frame_wrap_c;
            if (pixel_tick) begin
                X         <= x_d;
                Y         <= y_d;
                pipe_q[0] <= dec_d;
                for (int unsigned k = 1; k <= PIPE_DLY; k++) begin
                    pipe_q[k] <= pipe_q[k-1];
                end
                if (frame_wrap_c) begin
                    frame_cnt <= frame_cnt + 16'd1;
                end
            end
        end
    end

    assign {Hsync, Vsync, video_on} = pipe_q[PIPE_DLY];

endmodule
